// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file (regfile_mp) and its
// clear-sweep controller (regfile_clear_fsm).
//   rf_state_t   : controller states, SWEEP (array being zeroed) and RUN
//   DEF_*        : default geometry used when the parent does not override it
//   ZERO_IDX     : index of the hardwired zero register
//   sweep_first  : first index the clear sweep visits; the zero register is
//                  skipped when it is hardwired because it can never be read
// -----------------------------------------------------------------------------
package regfile_pkg;

   typedef enum logic {
      SWEEP = 1'b0,
      RUN   = 1'b1
   } rf_state_t;

   localparam int DEF_XLEN  = 32;
   localparam int DEF_NREG  = 32;
   localparam int DEF_NREAD = 2;

   localparam int ZERO_IDX  = 0;

   function automatic int sweep_first(input int zero_reg);
      return (zero_reg != 0) ? ZERO_IDX + 1 : ZERO_IDX;
   endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// -----------------------------------------------------------------------------
// regfile_clear_fsm
// Owns the SWEEP/RUN state, the sweep index and the registered ready flag.
// While sweeping it requests one zero-write per cycle at sweep_addr; the top
// level muxes that request onto the single array write port.
//
// Ports:
//   clock       in   sole clock, all state updates on posedge
//   reset       in   synchronous active-high; restarts the sweep, wins over clear
//   clear       in   single-cycle pulse; (re)starts a sweep
//   sweep_we    out  write a zero to sweep_addr at the next edge
//   sweep_addr  out  current sweep index (AW bits)
//   ready       out  registered; high only in RUN
// -----------------------------------------------------------------------------
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter  int NREG     = DEF_NREG,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(NREG)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   output logic          sweep_we,
   output logic [AW-1:0] sweep_addr,
   output logic          ready
);

   localparam logic [AW-1:0] IDX_FIRST = AW'(sweep_first(ZERO_REG));
   localparam logic [AW-1:0] IDX_LAST  = AW'(NREG - 1);

   rf_state_t     state_reg, state_next;
   logic [AW-1:0] idx_reg, idx_next;
   logic          ready_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= SWEEP;
         idx_reg   <= IDX_FIRST;
         ready_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         // ready tracks the state being entered so it is valid the cycle
         // after the edge, with no combinational path from state decode.
         ready_reg <= (state_next == RUN);
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      case (state_reg)
         SWEEP: begin
            if (clear) begin
               // A clear mid-sweep simply extends the sweep from the start.
               idx_next = IDX_FIRST;
            end else if (idx_reg == IDX_LAST) begin
               state_next = RUN;
               idx_next   = IDX_FIRST;
            end else begin
               idx_next = idx_reg + 1'b1;
            end
         end
         RUN: begin
            if (clear) begin
               state_next = SWEEP;
               idx_next   = IDX_FIRST;
            end
         end
         default: begin
            state_next = SWEEP;
            idx_next   = IDX_FIRST;
         end
      endcase
   end

   // The reset edge itself leaves the array untouched; zeroing starts on
   // the first edge after reset is released.
   assign sweep_we   = (state_reg == SWEEP) && !reset;
   assign sweep_addr = idx_reg;
   assign ready      = ready_reg;

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised register file: one synchronous write port (writeback), NREAD
// combinational read ports (decode), optional hardwired zero register, and a
// sequential clear sweep started by reset or by a clear pulse.
//
// Parameters: XLEN (data width), NREG (power of two, >= 4), NREAD (1..4),
//             ZERO_REG (1 = register 0 reads 0 and ignores writes),
//             AW (derived address width, not to be overridden).
//
// Ports:
//   clock      in   sole clock
//   reset      in   synchronous active-high; starts a sweep
//   clear      in   single-cycle pulse; starts a sweep, drops same-cycle write
//   RegWrite   in   write enable (ignored while sweeping)
//   RD         in   write address
//   WriteData  in   write data
//   ReadAddr   in   packed read addresses, port i at [i*AW +: AW]
//   ReadData   out  packed read data, port i at [i*XLEN +: XLEN]; 0 while sweeping
//   ready      out  high when the array is usable
//
// Build option: define REGFILE_BYPASS_EN to forward same-cycle WriteData to
// any read port addressing RD (write-through). Without it, a read of the
// address being written returns the value held before the edge.
// -----------------------------------------------------------------------------
module regfile_mp
   import regfile_pkg::*;
#(
   parameter  int XLEN     = DEF_XLEN,
   parameter  int NREG     = DEF_NREG,
   parameter  int NREAD    = DEF_NREAD,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(NREG)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  RegWrite,
   input  logic [AW-1:0]         RD,
   input  logic [XLEN-1:0]       WriteData,
   input  logic [NREAD*AW-1:0]   ReadAddr,
   output logic [NREAD*XLEN-1:0] ReadData,
   output logic                  ready
);

   localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_IDX);

   logic            sweep_we;
   logic [AW-1:0]   sweep_addr;
   logic            rd_is_zero;
   logic            wb_en;
   logic            mem_we;
   logic [AW-1:0]   mem_waddr;
   logic [XLEN-1:0] mem_wdata;

   logic [XLEN-1:0] rf_mem [NREG];

   regfile_clear_fsm #(
      .NREG     (NREG),
      .ZERO_REG (ZERO_REG)
   ) u_clear_fsm (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .sweep_we   (sweep_we),
      .sweep_addr (sweep_addr),
      .ready      (ready)
   );

   assign rd_is_zero = (ZERO_REG != 0) && (RD == ZERO_ADDR);

   // A writeback only lands in RUN, and is dropped (not queued) whenever the
   // same edge starts a sweep via clear or reset.
   assign wb_en = ready && RegWrite && !clear && !reset && !rd_is_zero;

   // Sweep and writeback share the single array write port; they are
   // mutually exclusive because wb_en requires RUN and sweep_we requires SWEEP.
   always_comb begin
      mem_we    = sweep_we || wb_en;
      mem_waddr = sweep_we ? sweep_addr : RD;
      mem_wdata = sweep_we ? '0 : WriteData;
   end

   always_ff @(posedge clock) begin
      if (mem_we) begin
         rf_mem[mem_waddr] <= mem_wdata;
      end
   end

   generate
      for (genvar gi = 0; gi < NREAD; gi++) begin : g_read
         logic [AW-1:0]   raddr;
         logic [XLEN-1:0] rdata;

         assign raddr = ReadAddr[gi*AW +: AW];

         always_comb begin
            rdata = rf_mem[raddr];
`ifdef REGFILE_BYPASS_EN
            if (wb_en && (raddr == RD)) begin
               rdata = WriteData;
            end
`endif
            // Forcing zero during the sweep hides partially cleared (or
            // never-initialised) entries; the zero register never holds
            // meaningful data so it is masked here rather than stored.
            if (!ready || ((ZERO_REG != 0) && (raddr == ZERO_ADDR))) begin
               rdata = '0;
            end
         end

         assign ReadData[gi*XLEN +: XLEN] = rdata;
      end
   endgenerate

endmodule
